// File: rtl/bram_pim_ctrl_pkg.sv
// Shared types and constants for the PIM BRAM controller.
//   state_t      : controller state (RUN, CLEAR)
//   MEM_MAXADDR  : default macro address width
//   MEM_MAXDATA  : widest macro data width
//   clog2()      : ceiling log2, never below 1, for pointer/count widths
package bram_pim_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int MEM_MAXADDR = 11;
  localparam int MEM_MAXDATA = 36;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bram_pim_ctrl_if.sv
// Request/response bus between a PIM sequencer (master) and the BRAM
// controller (slave).
//   req_valid/req_ready : request handshake
//   req_we/addr/wdata   : request payload (1 = write)
//   rsp_valid/rsp_ready : read response handshake
//   rsp_rdata           : read data, in request order
interface bram_pim_ctrl_if
  import bram_pim_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_MAXADDR,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_pim_rsp_fifo.sv
// Synchronous response FIFO with simultaneous push/pop.
//   clk, reset : clock, synchronous active-high reset
//   push/push_data : write an entry
//   pop        : consume the head entry (ignored when empty)
//   head_data  : head entry, read straight from registered storage
//   empty      : no entries
//   count      : current occupancy
module bram_pim_rsp_fifo
  import bram_pim_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];

  // A pop only counts when there is something to pop, so push+pop on an
  // empty FIFO behaves as a plain push and the count still stays consistent.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_reg[wr_ptr_reg] <= push_data;
  end

  // The credit scheme upstream guarantees a slot for every push.
  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/bram_pim_ctrl.sv
// Initiator for the PIM single-port BRAM macro.
//   clk, reset : shared clock, synchronous active-high reset
//   bus        : request/response bus (slave side)
//   mem_we/mem_addr/mem_data : macro write enable, address, write data
//   mem_out    : macro read data, valid RD_LATENCY cycles after address
// Optional feature macro BRAM_PIM_CTRL_CLEAR_EN: after reset, sweep zeros
// into every macro address before accepting requests.
module bram_pim_ctrl
  import bram_pim_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_MAXADDR,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bram_pim_ctrl_if.slave        bus,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam int CNT_W  = clog2(RESP_DEPTH + 1);
  localparam int CRED_W = clog2(RESP_DEPTH + RD_LATENCY + 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("RD_LATENCY must be in 1..4");
  end
  if (RESP_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
    $error("RESP_DEPTH must be at least RD_LATENCY+1");
  end

  state_t                  state;
  logic                    clearing;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    fire;
  logic                    rd_issue;
  logic                    req_ready_int;
  logic [RD_LATENCY-1:0]   rd_pipe_reg;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic [CRED_W-1:0]       cred_used;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;

`ifdef BRAM_PIM_CTRL_CLEAR_EN
  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg;
  logic [ADDR_WIDTH-1:0] clr_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
        if (&clr_cnt_reg) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign state    = state_reg;
  // Held off while reset is asserted so the pins show their reset values.
  assign clearing = (state_reg == CLEAR) && !reset;
  assign clr_addr = clr_cnt_reg;
`else
  assign state    = RUN;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  // Credits: every occupied FIFO slot plus every read still in the macro
  // pipe. A pop in the same cycle deliberately frees nothing, which keeps
  // rsp_ready off the req_ready path.
  always_comb begin
    cred_used = CRED_W'(fifo_count);
    for (int i = 0; i < RD_LATENCY; i++) begin
      cred_used = cred_used + CRED_W'(rd_pipe_reg[i]);
    end
  end

  assign req_ready_int = (state == RUN) && (cred_used < CRED_W'(RESP_DEPTH));
  assign bus.req_ready = req_ready_int;
  assign fire          = bus.req_valid && req_ready_int;
  assign rd_issue      = fire && !bus.req_we;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = addr_reg;
    mem_data = data_reg;
    if (clearing) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = '0;
    end else if (fire) begin
      mem_we   = bus.req_we;
      mem_addr = bus.req_addr;
      mem_data = bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg    <= '0;
      data_reg    <= '0;
      rd_pipe_reg <= '0;
    end else begin
      addr_reg       <= mem_addr;
      data_reg       <= mem_data;
      rd_pipe_reg[0] <= rd_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_pipe_reg[i] <= rd_pipe_reg[i-1];
      end
    end
  end

  bram_pim_rsp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pipe_reg[RD_LATENCY-1]),
    .push_data (mem_out),
    .pop       (bus.rsp_ready),
    .head_data (bus.rsp_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rsp_valid = !fifo_empty;

endmodule

// File: tb/tb_bram_pim_ctrl.sv
module tb_bram_pim_ctrl;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;

  bram_pim_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  bram_pim_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (1),
    .RESP_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_out  (mem_out)
  );

  always #5 clk = ~clk;

  // Single-port macro model, one cycle read latency.
  logic [DW-1:0] macro_mem [1<<AW];
  always @(posedge clk) begin
    if (mem_we) macro_mem[mem_addr] <= mem_data;
    mem_out <= macro_mem[mem_addr];
  end

  // rsp_ready: 0 = held low, 1 = held high, 2 = random per cycle
  int   rsp_mode = 0;
  logic rnd_ready = 1'b0;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);
  assign bus.rsp_ready = (rsp_mode == 1) || (rsp_mode == 2 && rnd_ready);

  int            checks = 0;
  int            failures = 0;
  int            rsp_cnt = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_rsp actual=0x%02h required=no response", bus.rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        $display("rsp %0d data=0x%02h expect=0x%02h", rsp_cnt, bus.rsp_rdata, e);
        chk("rsp_data", 32'(bus.rsp_rdata), 32'(e));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] e, output int stalls);
    bit ok;
    ok = 0;
    stalls = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1;
        chk("mem_we_issue", 32'(mem_we), 32'(we));
        chk("mem_addr_issue", 32'(mem_addr), 32'(a));
        if (we) chk("mem_data_issue", 32'(mem_data), 32'(d));
        else    exp_q.push_back(e);
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout actual=no accept required=accept addr=0x%03h", a);
    end
    $display("req we=%0d addr=0x%03h wdata=0x%02h stalls=%0d", we, a, d, stalls);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 just after reset release.
  task automatic post_reset_check();
`ifdef BRAM_PIM_CTRL_CLEAR_EN
    int bad;
    bad = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      if (bus.req_ready || !mem_we || mem_addr != AW'(i) || mem_data != '0) bad++;
    end
    chk("sweep_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    chk("sweep_run_ready", 32'(bus.req_ready), 32'd1);
    chk("sweep_run_we", 32'(mem_we), 32'd0);
`else
    @(negedge clk);
    chk("run_ready", 32'(bus.req_ready), 32'd1);
    chk("run_we", 32'(mem_we), 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int st, lat, acc, idx, base;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    vecs[0] = '{1'b1, 11'h010, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 11'h010, 8'h00, 8'hA5};
    for (int i = 0; i < 8; i++) begin
      vecs[2+i]  = '{1'b1, AW'(i), DW'(i), 8'h00};
      vecs[10+i] = '{1'b0, AW'(i), 8'h00, DW'(i)};
    end
    vecs[18] = '{1'b1, 11'h7FF, 8'h3C, 8'h00};
    vecs[19] = '{1'b0, 11'h7FF, 8'h00, 8'h3C};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    post_reset_check();

`ifdef BRAM_PIM_CTRL_CLEAR_EN
    rsp_mode = 1;
    issue(1'b0, 11'h007, 8'h00, 8'h00, st);
    wait_drain();
`endif

    // Table: write/read-after-write, preload, back-to-back reads, top address
    rsp_mode = 1;
    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, st);
      chk("no_stall", 32'(st), 32'd0);
    end
    wait_drain();

    // Read latency: rsp_valid appears RD_LATENCY+1 cycles after accept
    issue(1'b0, 11'h010, 8'h00, 8'hA5, st);
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) lat = n;
    end
    chk("rd_latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("idle_mem_we", 32'(mem_we), 32'd0);
    chk("idle_mem_addr_hold", 32'(mem_addr), 32'h010);
    @(posedge clk);
    #1;
    wait_drain();

    // Backpressure: only RESP_DEPTH reads accepted while consumer stalls
    rsp_mode = 0;
    base = rsp_cnt;
    acc = 0;
    idx = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(DW'(idx));
        acc++;
        idx++;
      end
      @(posedge clk);
      #1;
      bus.req_addr = AW'(idx);
      if (idx >= 8) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    rsp_mode = 1;
    for (int i = idx; i < 8; i++) issue(1'b0, AW'(i), 8'h00, DW'(i), st);
    wait_drain();
    chk("bp_total_rsp", 32'(rsp_cnt - base), 32'd8);

    // Reset with reads queued/in flight: everything discarded
    rsp_mode = 0;
    issue(1'b0, 11'h001, 8'h00, 8'h01, st);
    issue(1'b0, 11'h002, 8'h00, 8'h02, st);
    issue(1'b0, 11'h003, 8'h00, 8'h03, st);
    @(negedge clk);
    chk("pre_flush_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("flush_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    base = rsp_cnt;
    rsp_mode = 1;
    post_reset_check();
    repeat (6) @(negedge clk);
    chk("flush_no_stale", 32'(rsp_cnt - base), 32'd0);
    @(posedge clk);
    #1;

    // Random alternating write/read to the same address
    rsp_mode = 2;
    for (int k = 0; k < 500; k++) begin
      ra = AW'($urandom_range(0, 31));
      rd = DW'($urandom);
      issue(1'b1, ra, rd, 8'h00, st);
      issue(1'b0, ra, 8'h00, rd, st);
    end
    rsp_mode = 1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
